// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, widths and default parameters for the game state controller
package game_pkg;

  // Top-level game state, encoding is visible on the game_state port
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    WIN       = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int SCORE_W = 14;
  localparam int COINS_W = 10;
  localparam int LIVES_W = 3;
  localparam int TIMER_W = 8;

  // Defaults for the per-instance parameters
  localparam int DEF_TOTAL_COINS  = 244;
  localparam int DEF_COIN_POINTS  = 10;
  localparam int DEF_START_LIVES  = 3;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_SCORE_MAX    = 9999;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable 8-bit frame down-counter with expiry pulse
module frame_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // Expiry coincides with the tick that moves the count from 1 to 0, so the
  // consumer can react on the same edge the counter reaches zero. A load on
  // the same cycle wins and suppresses the expiry.
  assign expired = tick && !load && (count == TIMER_W'(1));

  // Load has priority over the frame tick; the counter rests at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - score, coins, lives and top-level game state sequencing
module game_state_controller
  import game_pkg::*;
#(
  parameter int TOTAL_COINS  = DEF_TOTAL_COINS,
  parameter int COIN_POINTS  = DEF_COIN_POINTS,
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int SCORE_MAX    = DEF_SCORE_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               coinTaken,
  input  logic               monsterHit,
  output game_state_t        game_state,
  output logic [SCORE_W-1:0] score,
  output logic [COINS_W-1:0] coins_left,
  output logic [LIVES_W-1:0] lives,
  output logic               freeze,
  output logic               respawn
);

  localparam logic [SCORE_W:0]   POINTS_EXT = (SCORE_W + 1)'(COIN_POINTS);
  localparam logic [SCORE_W:0]   CAP_EXT    = (SCORE_W + 1)'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] CAP        = SCORE_W'(SCORE_MAX);

  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic               last_coin;
  logic               timer_load;
  logic               timer_expired;

  // Saturating score increment, one bit wider so the carry is never lost
  always_comb begin
    score_sum  = {1'b0, score} + POINTS_EXT;
    score_next = (score_sum > CAP_EXT) ? CAP : score_sum[SCORE_W-1:0];
  end

  // The coin is credited before the hit, so a last coin turns a hit into a win
  assign last_coin  = coinTaken && (coins_left == COINS_W'(1));
  assign timer_load = (game_state == PLAY) && monsterHit && !last_coin;

  frame_timer u_death_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (TIMER_W'(DEATH_FRAMES)),
    .tick       (startOfFrame),
    .expired    (timer_expired)
  );

  // Game FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      game_state <= IDLE;
      score      <= '0;
      coins_left <= '0;
      lives      <= '0;
      freeze     <= 1'b1;
      respawn    <= 1'b0;
    end else begin
      respawn <= 1'b0;
      case (game_state)
        IDLE: begin
          if (startKey) begin
            score      <= '0;
            coins_left <= COINS_W'(TOTAL_COINS);
            lives      <= LIVES_W'(START_LIVES);
            respawn    <= 1'b1;
            freeze     <= 1'b0;
            game_state <= PLAY;
          end
        end
        PLAY: begin
          if (coinTaken) begin
            coins_left <= coins_left - COINS_W'(1);
            score      <= score_next;
          end
          if (last_coin) begin
            freeze     <= 1'b1;
            game_state <= WIN;
          end else if (monsterHit) begin
            lives      <= lives - LIVES_W'(1);
            freeze     <= 1'b1;
            game_state <= DYING;
          end
        end
        DYING: begin
          if (timer_expired) begin
            if (lives == '0) begin
              game_state <= GAME_OVER;
            end else begin
              respawn    <= 1'b1;
              freeze     <= 1'b0;
              game_state <= PLAY;
            end
          end
        end
        WIN, GAME_OVER: begin
          if (startKey) begin
            game_state <= IDLE;
          end
        end
        default: begin
          freeze     <= 1'b1;
          game_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - randomized and directed bench against a rule-level game model
module tb_game_state_controller;

  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_WIN = 3, S_OVER = 4;

  typedef struct {
    int total;
    int pts;
    int lives0;
    int death;
    int smax;
  } cfg_t;

  typedef struct {
    int st;
    int score;
    int coins;
    int lives;
    int frames;
    int respawn;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset_r = 1'b1;
  logic        sk[2];
  logic        sof[2];
  logic        coin[2];
  logic        hit[2];
  logic [2:0]  st[2];
  logic [13:0] sc[2];
  logic [9:0]  cl[2];
  logic [2:0]  lv[2];
  logic        fr[2];
  logic        rs[2];

  cfg_t cfg[2];
  mdl_t mdl[2];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  game_state_controller u_dut0 (
    .clk          (clk),
    .reset        (reset_r),
    .startOfFrame (sof[0]),
    .startKey     (sk[0]),
    .coinTaken    (coin[0]),
    .monsterHit   (hit[0]),
    .game_state   (st[0]),
    .score        (sc[0]),
    .coins_left   (cl[0]),
    .lives        (lv[0]),
    .freeze       (fr[0]),
    .respawn      (rs[0])
  );

  game_state_controller #(
    .TOTAL_COINS  (2),
    .COIN_POINTS  (5000),
    .START_LIVES  (3),
    .DEATH_FRAMES (3),
    .SCORE_MAX    (9999)
  ) u_dut1 (
    .clk          (clk),
    .reset        (reset_r),
    .startOfFrame (sof[1]),
    .startKey     (sk[1]),
    .coinTaken    (coin[1]),
    .monsterHit   (hit[1]),
    .game_state   (st[1]),
    .score        (sc[1]),
    .coins_left   (cl[1]),
    .lives        (lv[1]),
    .freeze       (fr[1]),
    .respawn      (rs[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame-level step of the game rules
  function automatic mdl_t step(mdl_t m, cfg_t c, logic rst, logic key, logic frame,
                                logic got_coin, logic got_hit);
    mdl_t n;
    n = m;
    n.respawn = 0;
    if (rst) begin
      n.st = S_IDLE; n.score = 0; n.coins = 0; n.lives = 0; n.frames = 0;
      return n;
    end
    if (m.st == S_IDLE && key) begin
      n.score = 0; n.coins = c.total; n.lives = c.lives0;
      n.st = S_PLAY; n.respawn = 1;
    end else if (m.st == S_PLAY) begin
      if (got_coin) begin
        n.coins = m.coins - 1;
        n.score = (m.score + c.pts > c.smax) ? c.smax : m.score + c.pts;
      end
      if (got_coin && n.coins == 0) begin
        n.st = S_WIN;
      end else if (got_hit) begin
        n.lives = m.lives - 1;
        n.frames = c.death;
        n.st = S_DYING;
      end
    end else if (m.st == S_DYING && frame) begin
      n.frames = m.frames - 1;
      if (n.frames == 0) begin
        if (m.lives == 0) n.st = S_OVER;
        else begin
          n.st = S_PLAY;
          n.respawn = 1;
        end
      end
    end else if ((m.st == S_WIN || m.st == S_OVER) && key) begin
      n.st = S_IDLE;
    end
    return n;
  endfunction

  task automatic compare(input int d);
    check($sformatf("u%0d.state", d), 32'(st[d]), 32'(mdl[d].st));
    check($sformatf("u%0d.score", d), 32'(sc[d]), 32'(mdl[d].score));
    check($sformatf("u%0d.coins", d), 32'(cl[d]), 32'(mdl[d].coins));
    check($sformatf("u%0d.lives", d), 32'(lv[d]), 32'(mdl[d].lives));
    check($sformatf("u%0d.freeze", d), 32'(fr[d]), (mdl[d].st != S_PLAY) ? 32'd1 : 32'd0);
    check($sformatf("u%0d.respawn", d), 32'(rs[d]), 32'(mdl[d].respawn));
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      mdl[d] = step(mdl[d], cfg[d], reset_r, sk[d], sof[d], coin[d], hit[d]);
    #1;
    for (int d = 0; d < 2; d++) begin
      compare(d);
      sk[d] = 1'b0; sof[d] = 1'b0; coin[d] = 1'b0; hit[d] = 1'b0;
    end
  endtask

  task automatic frames0(input int count);
    for (int i = 0; i < count; i++) begin
      sof[0] = 1'b1;
      cyc();
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cslot[2];
    int hslot[2];
    cfg[0] = '{244, 10, 3, 60, 9999};
    cfg[1] = '{2, 5000, 3, 3, 9999};
    for (int d = 0; d < 2; d++) begin
      sk[d] = 1'b0; sof[d] = 1'b0; coin[d] = 1'b0; hit[d] = 1'b0;
      mdl[d] = '{0, 0, 0, 0, 0, 0};
    end

    // reset state
    reset_r = 1'b1;
    cyc();
    reset_r = 1'b0;
    check("rst.state", 32'(st[0]), 0);
    check("rst.coins", 32'(cl[0]), 0);
    check("rst.lives", 32'(lv[0]), 0);
    check("rst.freeze", 32'(fr[0]), 1);
    check("rst.respawn", 32'(rs[0]), 0);

    // start game
    sk[0] = 1'b1;
    cyc();
    check("start.state", 32'(st[0]), S_PLAY);
    check("start.lives", 32'(lv[0]), 3);
    check("start.coins", 32'(cl[0]), 244);
    check("start.score", 32'(sc[0]), 0);
    check("start.respawn", 32'(rs[0]), 1);
    check("start.freeze", 32'(fr[0]), 0);
    cyc();
    check("start.respawn_drop", 32'(rs[0]), 0);

    // coin accumulation
    for (int i = 0; i < 3; i++) begin
      coin[0] = 1'b1;
      cyc();
      frames0(1);
    end
    check("coins.score", 32'(sc[0]), 30);
    check("coins.left", 32'(cl[0]), 241);

    // three deaths ending in game over
    for (int k = 0; k < 3; k++) begin
      hit[0] = 1'b1;
      cyc();
      check("hit.state", 32'(st[0]), S_DYING);
      check("hit.lives", 32'(lv[0]), 32'(2 - k));
      check("hit.freeze", 32'(fr[0]), 1);
      frames0(59);
      check("dying59.state", 32'(st[0]), S_DYING);
      sof[0] = 1'b1;
      cyc();
      if (k < 2) begin
        check("revive.state", 32'(st[0]), S_PLAY);
        check("revive.respawn", 32'(rs[0]), 1);
      end else begin
        check("over.state", 32'(st[0]), S_OVER);
        check("over.lives", 32'(lv[0]), 0);
        check("over.respawn", 32'(rs[0]), 0);
      end
      cyc();
    end
    sk[0] = 1'b1;
    cyc();
    check("over_key.state", 32'(st[0]), S_IDLE);

    // reset in the middle of a death sequence
    sk[0] = 1'b1;
    cyc();
    hit[0] = 1'b1;
    cyc();
    frames0(30);
    reset_r = 1'b1;
    cyc();
    reset_r = 1'b0;
    check("midrst.state", 32'(st[0]), S_IDLE);
    check("midrst.score", 32'(sc[0]), 0);
    check("midrst.coins", 32'(cl[0]), 0);
    check("midrst.lives", 32'(lv[0]), 0);
    check("midrst.freeze", 32'(fr[0]), 1);
    check("midrst.respawn", 32'(rs[0]), 0);
    cyc();
    check("midrst.respawn_after", 32'(rs[0]), 0);

    // last coin together with a hit, with score saturation on the second instance
    sk[1] = 1'b1;
    cyc();
    coin[1] = 1'b1;
    cyc();
    check("u1.first_coin.score", 32'(sc[1]), 5000);
    check("u1.first_coin.coins", 32'(cl[1]), 1);
    sof[1] = 1'b1;
    cyc();
    coin[1] = 1'b1;
    hit[1] = 1'b1;
    cyc();
    check("u1.win.state", 32'(st[1]), S_WIN);
    check("u1.win.lives", 32'(lv[1]), 3);
    check("u1.win.coins", 32'(cl[1]), 0);
    check("u1.win.score", 32'(sc[1]), 9999);
    sk[1] = 1'b1;
    cyc();
    check("u1.win_key.state", 32'(st[1]), S_IDLE);

    // randomized play on both instances
    for (int f = 0; f < 900; f++) begin
      for (int d = 0; d < 2; d++) begin
        cslot[d] = int'($urandom_range(0, 5));
        hslot[d] = int'($urandom_range(0, 15));
      end
      for (int k = 0; k < 4; k++) begin
        for (int d = 0; d < 2; d++) begin
          sof[d]  = (k == 0);
          coin[d] = (cslot[d] == k);
          hit[d]  = (hslot[d] == k);
          sk[d]   = ($urandom_range(0, 23) == 0);
        end
        reset_r = ($urandom_range(0, 999) == 0);
        cyc();
      end
    end
    reset_r = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Consumes the per-frame event pulses from the collision stage (`coinTaken`, `monsterHit`) and turns them into game progress: score, coins remaining, lives and the top-level game state. Drives the freeze/respawn controls for the pacman and monster movers and the score/lives values for the on-screen display. It sits directly downstream of the hit manager, in the same clock domain.

## Interface
Parameters:
- `TOTAL_COINS`, 244: coins on the board at the start of each game; range 1..1023.
- `COIN_POINTS`, 10: score added per coin taken.
- `START_LIVES`, 3: lives at game start; range 1..7.
- `DEATH_FRAMES`, 60: frames spent in DYING, about 2 s at 30 Hz; range 1..255.
- `SCORE_MAX`, 9999: saturation ceiling for the score.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle pulse at the start of every frame.
- `startKey`, in, 1: one-cycle pulse from the keypad debouncer.
- `coinTaken`, in, 1: one-cycle pulse, at most once per frame.
- `monsterHit`, in, 1: one-cycle pulse, at most once per frame.
- `game_state`, out, 3: current state, encoded as `game_state_t`.
- `score`, out, 14: binary score, 0..`SCORE_MAX`.
- `coins_left`, out, 10: coins not yet taken.
- `lives`, out, 3: remaining lives.
- `freeze`, out, 1: high whenever the state is not PLAY; the movers hold position while it is high.
- `respawn`, out, 1: one-cycle pulse; the movers reload their start positions.

## Operation
States and transitions:
- **IDLE**
  - `startKey` → load `score`=0, `coins_left`=`TOTAL_COINS`, `lives`=`START_LIVES`.
  - Pulse `respawn` and go to PLAY.
- **PLAY**
  - `coinTaken` → `coins_left`−1; `score` increases by `COIN_POINTS`, saturating at `SCORE_MAX`.
  - If the decrement takes `coins_left` to 0, go to WIN.
  - `monsterHit` (and not winning) → `lives`−1, load the frame timer with `DEATH_FRAMES`, go to DYING.
- **DYING**
  - The timer decrements on each `startOfFrame`.
  - On the `startOfFrame` that takes it from 1 to 0:
    - if `lives`==0, go to GAME_OVER;
    - otherwise pulse `respawn` and go to PLAY.
  - `coinTaken` and `monsterHit` are ignored.
- **WIN / GAME_OVER**
  - All values are held.
  - `startKey` → go to IDLE. A further `startKey` is needed to begin a new game.

Boundary and priority rules:
- `coinTaken` and `monsterHit` in the same cycle: the coin is credited first.
  - If that coin is the last one, the result is WIN and no life is lost.
  - Otherwise both apply and the next state is DYING.
- `startKey` is ignored in PLAY and DYING.
- `coinTaken` while `coins_left`==0 cannot occur (the block has already left PLAY). No underflow is allowed.
- `lives` never underflows: a hit is only accepted in PLAY, and `lives`≥1 there.
- Score saturates: the next value is `SCORE_MAX` whenever `score` + `COIN_POINTS` > `SCORE_MAX`. Compute the sum one bit wider to detect this.
- A `reset` mid-game returns to IDLE with all counters cleared, regardless of state or timer.

## Timing
- All outputs are registered. Any input pulse at cycle n is reflected in the outputs at n+1.
- `respawn` is high for exactly the one cycle in which `game_state` first reads PLAY.
- `freeze` is a registered copy: high from the cycle a state other than PLAY becomes visible.
- Reset values: `game_state`=IDLE, `score`=0, `coins_left`=0, `lives`=0, `freeze`=1, `respawn`=0, timer=0.
- DYING lasts exactly `DEATH_FRAMES` `startOfFrame` pulses. The pulse that causes entry to DYING is not counted.

## Structure
- Shared package `game_pkg`:
  - `game_state_t`: IDLE=0, PLAY=1, DYING=2, WIN=3, GAME_OVER=4.
  - Width constants `SCORE_W`=14, `COINS_W`=10, `LIVES_W`=3.
  - The parameters are declared here and overridden per instance.
- One sub-module, `frame_timer`:
  - An 8-bit loadable down-counter that decrements on `startOfFrame`.
  - Outputs a one-cycle `expired` pulse on the 1→0 transition.
  - It is reused for later power-pellet timing.

## Test plan
- **Start game:** reset, then `startKey` → next cycle: `game_state`=PLAY, `lives`=3, `coins_left`=244, `score`=0, `respawn`=1 for one cycle, `freeze`=0.
- **Coin accumulation:**
  - 3 `coinTaken` pulses → `score`=30, `coins_left`=241.
  - Preload `score` to 9995, then one coin → `score`=9999.
- **Death and respawn:**
  - `monsterHit` in PLAY → `lives`=2, DYING, `freeze`=1.
  - After exactly 60 `startOfFrame` pulses → PLAY with `respawn`=1.
  - On the 59th pulse it is still DYING.
- **Game over:** 3 hits with `START_LIVES`=3 → after the third DYING expires, `game_state`=GAME_OVER and `lives`=0. `startKey` → IDLE.
- **Simultaneous last coin and hit:** with `TOTAL_COINS`=2, take 1 coin, then `coinTaken` and `monsterHit` in the same cycle → WIN, `lives`=3, `coins_left`=0.
- **Reset mid-DYING:** assert `reset` with the timer at 30 → next cycle: IDLE, all counters 0, `freeze`=1, no `respawn` pulse.
